// File: rtl/dac_spi_out.sv
// Output stage: re-samples the 8-bit mix at a fixed rate and shifts each sample
// out as a 16-bit DAC121S101 frame {2'bxx, 2'b00 power-down, 12-bit code}.
module dac_spi_out #(
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_DIV = 2500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [7:0] SAMPLE_IN,
  input  logic       MUTE,
  output logic       SCLK,
  output logic       SYNC_N,
  output logic       SDATA,
  output logic       BUSY,
  output logic       FRAME_DONE,
  output logic       OVERRUN,
  output logic [1:0] DBG_STATE
);

  localparam int RW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [RW-1:0] RATE_LAST = RW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [RW-1:0] rate_q, rate_d;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   word_q, word_d;
  logic          sclk_q, sclk_d;
  logic          sync_n_q, sync_n_d;
  logic          sdata_q, sdata_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic [7:0]    code_sel;

  always_comb begin
    rate_d   = rate_q;
    state_d  = state_q;
    half_d   = half_q;
    bit_d    = bit_q;
    word_d   = word_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    sdata_d  = sdata_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    code_sel = MUTE ? 8'h80 : SAMPLE_IN;
    tick     = CE && (rate_q == '0);

    // With CE low nothing moves, so a frame simply stretches.
    if (CE) begin
      rate_d = (rate_q == RATE_LAST) ? '0 : rate_q + RW'(1);
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            word_d   = {4'b0000, code_sel, 4'b0000};
            state_d  = ST_SHIFT;
            sync_n_d = 1'b0;
            sclk_d   = 1'b1;
            half_d   = '0;
            bit_d    = 4'd15;
            sdata_d  = word_d[15];
          end
        end
        ST_SHIFT: begin
          if (half_q == HALF_LAST) begin
            half_d = '0;
            sclk_d = ~sclk_q;
            // SDATA advances only on the SCLK rising edge; the DAC samples on falling.
            if (!sclk_q) begin
              if (bit_q == 4'd0) begin
                state_d  = ST_DONE;
                sync_n_d = 1'b1;
                done_d   = 1'b1;
                sdata_d  = 1'b0;
              end else begin
                bit_d   = bit_q - 4'd1;
                sdata_d = word_q[bit_q - 4'd1];
              end
            end
          end else begin
            half_d = half_q + HW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (tick && (state_q != ST_IDLE)) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rate_q   <= '0;
      state_q  <= ST_IDLE;
      half_q   <= '0;
      bit_q    <= 4'd0;
      word_q   <= 16'h0000;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      sdata_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      rate_q   <= rate_d;
      state_q  <= state_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      sdata_q  <= sdata_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign SCLK       = sclk_q;
  assign SYNC_N     = sync_n_q;
  assign SDATA      = sdata_q;
  assign BUSY       = (state_q == ST_SHIFT);
  assign FRAME_DONE = done_q;
  assign OVERRUN    = ovr_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_dac_spi_out.sv
// Bench for dac_spi_out: an SPI receiver rebuilds each frame and compares it
// against words predicted from the sample-rate and frame-format rules.
module tb_dac_spi_out;
  localparam int CD          = 2;
  localparam int SD_A        = 100;
  localparam int SD_B        = 40;
  localparam int FRAME_EDGES = 32 * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic [7:0] sample_in = 8'h80;
  logic       mute = 1'b0;

  logic       a_sclk, a_sync_n, a_sdata, a_busy, a_fd, a_ovr;
  logic [1:0] a_dbg;
  logic       b_sclk, b_sync_n, b_sdata, b_busy, b_fd, b_ovr;
  logic [1:0] b_dbg;

  int checks = 0;
  int passes = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_b_word[$];
  int          exp_b_tick[$];
  int   ce_cnt;
  logic ce_seen_q;
  bit   mon_a_en = 1'b0;
  bit   mon_b_en = 1'b0;

  always #5 clk = ~clk;

  dac_spi_out #(.CLK_DIV(CD), .SAMPLE_DIV(SD_A)) u_dut (
    .CLK(clk), .RST(rst), .CE(ce), .SAMPLE_IN(sample_in), .MUTE(mute),
    .SCLK(a_sclk), .SYNC_N(a_sync_n), .SDATA(a_sdata), .BUSY(a_busy),
    .FRAME_DONE(a_fd), .OVERRUN(a_ovr), .DBG_STATE(a_dbg)
  );

  dac_spi_out #(.CLK_DIV(CD), .SAMPLE_DIV(SD_B)) u_ovr (
    .CLK(clk), .RST(rst), .CE(ce), .SAMPLE_IN(sample_in), .MUTE(mute),
    .SCLK(b_sclk), .SYNC_N(b_sync_n), .SDATA(b_sdata), .BUSY(b_busy),
    .FRAME_DONE(b_fd), .OVERRUN(b_ovr), .DBG_STATE(b_dbg)
  );

  // Count of CE-enabled edges since reset: the sample-rate timebase of the model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_cnt    <= 0;
      ce_seen_q <= 1'b0;
    end else begin
      ce_seen_q <= ce;
      if (ce) ce_cnt <= ce_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model_word(input logic [7:0] s, input logic m);
    int code12;
    code12 = (m ? 128 : int'(s)) * 16;
    return 16'(code12);
  endfunction

  // Receiver for the main instance.
  logic        a_prev_sclk, a_prev_fd;
  logic [2:0]  a_prev_pins;
  logic [15:0] a_shreg;
  int          a_nbits, a_cyc, a_gaps;
  bit          a_in_frame;

  always @(negedge clk) begin
    if (rst || !mon_a_en) begin
      a_in_frame  = 1'b0;
      a_prev_sclk = 1'b1;
      a_prev_fd   = 1'b0;
      a_prev_pins = {a_sclk, a_sync_n, a_sdata};
    end else begin
      if (a_in_frame) begin
        a_cyc++;
        if (!ce_seen_q) begin
          a_gaps++;
          check("freeze", {29'd0, a_sclk, a_sync_n, a_sdata}, {29'd0, a_prev_pins});
        end
      end
      if (a_prev_fd && ce_seen_q) check("fd_pulse", a_fd, 0);
      if (!a_in_frame && !a_sync_n) begin
        a_in_frame = 1'b1;
        a_cyc      = 0;
        a_gaps     = 0;
        a_nbits    = 0;
        a_shreg    = 16'h0;
        check("busy_start", a_busy, 1);
      end
      if (a_in_frame && !a_sync_n && a_prev_sclk && !a_sclk) begin
        a_shreg = {a_shreg[14:0], a_sdata};
        a_nbits++;
      end
      if (a_fd && !a_prev_fd) begin
        check("fd_in_frame", a_in_frame, 1);
        check("fd_latency", a_cyc, FRAME_EDGES + a_gaps);
        check("bit_count", a_nbits, 16);
        check("sync_high_done", a_sync_n, 1);
        if (exp_q.size() == 0) check("exp_available", exp_q.size(), 1);
        else check("word", a_shreg, exp_q.pop_front());
        a_in_frame = 1'b0;
      end
      a_prev_sclk = a_sclk;
      a_prev_fd   = a_fd;
      a_prev_pins = {a_sclk, a_sync_n, a_sdata};
    end
  end

  // Receiver for the overrun instance.
  logic        b_prev_sclk, b_prev_fd;
  logic [15:0] b_shreg;
  int          b_nbits;

  always @(negedge clk) begin
    if (rst || !mon_b_en) begin
      b_prev_sclk = 1'b1;
      b_prev_fd   = 1'b0;
      b_nbits     = 0;
      b_shreg     = 16'h0;
    end else begin
      if (!b_sync_n && b_prev_sclk && !b_sclk) begin
        b_shreg = {b_shreg[14:0], b_sdata};
        b_nbits++;
      end
      if (b_fd && !b_prev_fd) begin
        check("b_bit_count", b_nbits, 16);
        if (exp_b_word.size() == 0) check("b_exp_available", exp_b_word.size(), 1);
        else begin
          check("b_word", b_shreg, exp_b_word.pop_front());
          check("b_fd_time", ce_cnt - exp_b_tick.pop_front(), FRAME_EDGES + 1);
        end
        b_nbits = 0;
        b_shreg = 16'h0;
      end
      b_prev_sclk = b_sclk;
      b_prev_fd   = b_fd;
    end
  end

  // Drives one frame on the main instance; returns just before the next tick edge.
  task automatic run_frame(input logic [7:0] s, input logic m, input int gap_at,
                           input int gap_len, input bit abort);
    int n = 0;
    ce        = 1'b1;
    sample_in = s;
    mute      = m;
    exp_q.push_back(model_word(s, m));
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) check("sync_fall", a_sync_n, 0);
      if (abort && n == 10) begin
        #1 rst = 1'b1;
        #1;
        check("rst_sclk", a_sclk, 1);
        check("rst_sync_n", a_sync_n, 1);
        check("rst_busy", a_busy, 0);
        check("rst_fd", a_fd, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        #1 rst = 1'b0;
        ce = 1'b1;
        return;
      end
      ce        = (n >= gap_at && n < gap_at + gap_len) ? 1'b0 : 1'b1;
      sample_in = 8'($urandom);
      mute      = 1'($urandom);
      if (ce && (ce_cnt % SD_A == 0)) return;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  next_free;
    logic ovr_exp;
    rst = 1'b1;
    ce  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sclk", a_sclk, 1);
    check("reset_sync_n", a_sync_n, 1);
    check("reset_sdata", a_sdata, 0);
    check("reset_busy", a_busy, 0);
    check("reset_fd", a_fd, 0);
    check("reset_overrun", a_ovr, 0);
    check("reset_state", a_dbg, 0);
    #1 rst = 1'b0;
    mon_a_en = 1'b1;

    run_frame(8'hA5, 1'b0, 0, 0, 1'b0);
    run_frame(8'hFF, 1'b1, 0, 0, 1'b0);
    run_frame(8'h5A, 1'b0, 20, 7, 1'b0);
    run_frame(8'h3C, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 256; i++) run_frame(8'(i), 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 24; i++)
      run_frame(8'($urandom), 1'($urandom), $urandom_range(1, 50), $urandom_range(0, 7), 1'b0);
    check("a_exp_drained", exp_q.size(), 0);
    check("a_overrun", a_ovr, 0);
    mon_a_en = 1'b0;

    // Overrun scenario: frames longer than the sample period.
    #1 rst = 1'b1;
    @(negedge clk);
    mon_b_en = 1'b1;
    #1 rst = 1'b0;
    ce        = 1'b1;
    ovr_exp   = 1'b0;
    next_free = 0;
    while (ce_cnt < 236) begin
      check("b_overrun", b_ovr, ovr_exp);
      sample_in = 8'($urandom);
      mute      = 1'($urandom);
      if (ce_cnt % SD_B == 0) begin
        if (ce_cnt >= next_free) begin
          exp_b_word.push_back(model_word(sample_in, mute));
          exp_b_tick.push_back(ce_cnt);
          next_free = ce_cnt + FRAME_EDGES + 1;
        end else begin
          ovr_exp = 1'b1;
        end
      end
      @(negedge clk);
    end
    check("b_overrun_final", b_ovr, 1);
    check("b_exp_drained", exp_b_word.size(), 0);
    mon_b_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
